// File: rtl/result_serializer_pkg.sv
// result_serializer_pkg
// Shared types and constants for the result serializer: FSM state encoding,
// number of datapath results, beat index width and the checksum beat index.
package result_serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int NUM_RESULTS = 6;  // s1..s6
  localparam int IDX_W       = 3;  // wide enough for indices 0..6
  localparam int SUM_IDX     = 6;  // index of the trailing checksum beat

endpackage

// File: rtl/result_serializer_sum6.sv
// result_sum6
// Combinational six-input adder producing the burst checksum. The result is
// BW bits wide, so carries out of the top bit are dropped (mod 2^BW).
// Ports:
//   s1..s6 : input  [BW-1:0] operands
//   sum    : output [BW-1:0] (s1+s2+s3+s4+s5+s6) mod 2^BW
module result_sum6 #(
  parameter int BW = 8
) (
  input  logic [BW-1:0] s1,
  input  logic [BW-1:0] s2,
  input  logic [BW-1:0] s3,
  input  logic [BW-1:0] s4,
  input  logic [BW-1:0] s5,
  input  logic [BW-1:0] s6,
  output logic [BW-1:0] sum
);

  assign sum = s1 + s2 + s3 + s4 + s5 + s6;

endmodule

// File: rtl/result_serializer.sv
// result_serializer
// Captures one parallel set of six datapath results per in_valid/in_ready
// handshake and streams it out one word per beat, tagged with its index,
// optionally followed by a checksum beat (idx 6).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : upstream handshake for the result set
//   s1..s6              : result words, sampled only on the input handshake
//   out_valid/out_ready : downstream per-beat handshake
//   out_data, out_idx   : current word and its index (0..5 results, 6 checksum)
//   out_last            : marks the final beat of the burst
//   busy                : a burst is held or being emitted
module result_serializer
  import result_serializer_pkg::*;
#(
  parameter int BW       = 8,
  parameter bit EMIT_SUM = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BW-1:0]    s1,
  input  logic [BW-1:0]    s2,
  input  logic [BW-1:0]    s3,
  input  logic [BW-1:0]    s4,
  input  logic [BW-1:0]    s5,
  input  logic [BW-1:0]    s6,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BW-1:0]    out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy
);

  localparam int NUM_WORDS = NUM_RESULTS + 1;
  localparam logic [IDX_W-1:0] LAST_IDX =
    EMIT_SUM ? IDX_W'(SUM_IDX) : IDX_W'(NUM_RESULTS - 1);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [BW-1:0]    bank_reg [NUM_WORDS];
  logic [BW-1:0]    s_arr [NUM_RESULTS];
  logic [BW-1:0]    checksum;
  logic             load;
  logic             is_last;

  assign s_arr[0] = s1;
  assign s_arr[1] = s2;
  assign s_arr[2] = s3;
  assign s_arr[3] = s4;
  assign s_arr[4] = s5;
  assign s_arr[5] = s6;

  result_sum6 #(.BW(BW)) u_sum (
    .s1  (s1),
    .s2  (s2),
    .s3  (s3),
    .s4  (s4),
    .s5  (s5),
    .s6  (s6),
    .sum (checksum)
  );

  assign is_last = (idx_reg == LAST_IDX);

  // Next-state logic. in_ready is gated by rst so a set offered during reset
  // is never handshaken. On the final beat in_ready follows out_ready
  // combinationally, which lets a new set load with no bubble between bursts.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    load       = 1'b0;
    in_ready   = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) begin
          load       = 1'b1;
          idx_next   = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (!is_last) begin
            idx_next = idx_reg + 1'b1;
          end else begin
            in_ready = !rst;
            idx_next = '0;
            if (in_valid && !rst) begin
              load = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  // Word bank needs no reset: it is only observed while in SEND, and SEND is
  // always entered through a load.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < NUM_RESULTS; i++) begin
        bank_reg[i] <= s_arr[i];
      end
      bank_reg[SUM_IDX] <= checksum;
    end
  end

  assign busy      = (state_reg == SEND);
  assign out_valid = busy;
  assign out_idx   = idx_reg;
  assign out_last  = busy && is_last;
  assign out_data  = busy ? bank_reg[idx_reg] : '0;

endmodule

// File: tb/tb_result_serializer.sv
module tb_result_serializer;

  localparam int BW = 8;

  typedef struct {
    logic [BW-1:0] d;
    logic [2:0]    i;
    logic          l;
    int            cyc;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [BW-1:0] s [6];

  logic          in_ready  [2];
  logic          out_valid [2];
  logic          out_last  [2];
  logic          busy      [2];
  logic [BW-1:0] out_data  [2];
  logic [2:0]    out_idx   [2];

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  bit started = 1'b0;

  // Observed handshaken beats, for the directed literal checks.
  beat_t log0[$];
  beat_t log1[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    started <= 1'b1;
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", nm, k, act, exp, $time);
    end
  endtask

  // Instance 0: EMIT_SUM=1 (7-beat bursts); instance 1: EMIT_SUM=0 (6-beat).
  // Both share all inputs; each has its own reference model.
  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam bit EMIT = (gi == 0);

    result_serializer #(.BW(BW), .EMIT_SUM(EMIT)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready[gi]),
      .s1        (s[0]),
      .s2        (s[1]),
      .s3        (s[2]),
      .s4        (s[3]),
      .s5        (s[4]),
      .s6        (s[5]),
      .out_valid (out_valid[gi]),
      .out_ready (out_ready),
      .out_data  (out_data[gi]),
      .out_idx   (out_idx[gi]),
      .out_last  (out_last[gi]),
      .busy      (busy[gi])
    );

    // Reference model: a queue of the beats still owed to the consumer.
    // The head is what must be on the output; the queue being empty means idle.
    beat_t q[$];

    always @(negedge clk) begin
      beat_t e;
      logic  has;
      logic  exp_ir;
      int    sum;
      if (started) begin
        has   = (q.size() > 0);
        e.d   = '0;
        e.i   = '0;
        e.l   = 1'b0;
        e.cyc = 0;
        if (has) e = q[0];
        exp_ir = !rst && (!has || (out_ready && e.l));

        chk("out_valid", gi, 32'(out_valid[gi]), 32'(has));
        chk("busy",      gi, 32'(busy[gi]),      32'(has));
        chk("in_ready",  gi, 32'(in_ready[gi]),  32'(exp_ir));
        chk("out_data",  gi, 32'(out_data[gi]),  32'(e.d));
        chk("out_idx",   gi, 32'(out_idx[gi]),   32'(e.i));
        chk("out_last",  gi, 32'(out_last[gi]),  32'(e.l));

        if (rst) begin
          q.delete();
        end else begin
          if (has && out_ready) begin
            e.cyc = cyc;
            if (gi == 0) log0.push_back(e);
            else         log1.push_back(e);
            void'(q.pop_front());
          end
          if (in_valid && exp_ir) begin
            sum = 0;
            for (int k = 0; k < 6; k++) begin
              e.d   = s[k];
              e.i   = 3'(k);
              e.l   = !EMIT && (k == 5);
              e.cyc = 0;
              q.push_back(e);
              sum += int'(s[k]);
            end
            if (EMIT) begin
              e.d   = BW'(sum % 256);
              e.i   = 3'd6;
              e.l   = 1'b1;
              e.cyc = 0;
              q.push_back(e);
            end
          end
        end
      end
    end
  end

  task automatic load_set(input int a, input int b, input int c,
                          input int d, input int e, input int f);
    s[0] = BW'(a); s[1] = BW'(b); s[2] = BW'(c);
    s[3] = BW'(d); s[4] = BW'(e); s[5] = BW'(f);
  endtask

  // Wait (bounded) until instance k shows in_ready, let that edge pass.
  task automatic wait_accept(input int k);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (in_ready[k] && in_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept_timeout", k, 32'(ok), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idx(input int k, input int idx);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (out_valid[k] && out_idx[k] == 3'(idx)) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idx_timeout", k, 32'(ok), 32'd1);
  endtask

  initial begin
    int  exp_a [7];
    bit  ok;
    exp_a = '{13, 30, 3, 33, 7, 40, 126};
    load_set(0, 0, 0, 0, 0, 0);

    // Reset: in_ready low while rst is asserted, outputs idle afterwards.
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 0, 32'(in_ready[0]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 0, 32'(in_ready[0]), 32'd1);
    chk("post_rst_out_valid", 0, 32'(out_valid[0]), 32'd0);
    chk("post_rst_out_data", 0, 32'(out_data[0]), 32'd0);
    @(posedge clk); #1;

    // 1. Basic burst.
    out_ready = 1'b1;
    log0.delete();
    load_set(13, 30, 3, 33, 7, 40);
    in_valid = 1'b1;
    wait_accept(0);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("t1_count", 0, 32'(log0.size()), 32'd7);
    for (int k = 0; k < 7; k++) begin
      if (k < log0.size()) begin
        chk("t1_data", 0, 32'(log0[k].d), 32'(exp_a[k]));
        chk("t1_idx",  0, 32'(log0[k].i), 32'(k));
        chk("t1_last", 0, 32'(log0[k].l), 32'(k == 6));
        if (k > 0) chk("t1_consec", 0, 32'(log0[k].cyc - log0[k-1].cyc), 32'd1);
      end
    end
    chk("t1_busy_after", 0, 32'(busy[0]), 32'd0);

    // 2. Back-pressure at idx 2 for three cycles.
    log0.delete();
    in_valid = 1'b1;
    wait_accept(0);
    in_valid = 1'b0;
    wait_idx(0, 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t2_hold_data", 0, 32'(out_data[0]), 32'd3);
      chk("t2_hold_idx",  0, 32'(out_idx[0]),  32'd2);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("t2_count", 0, 32'(log0.size()), 32'd7);
    for (int k = 0; k < 7; k++) begin
      if (k < log0.size()) chk("t2_data", 0, 32'(log0[k].d), 32'(exp_a[k]));
    end
    if (log0.size() == 7) begin
      chk("t2_stall_len", 0, 32'(log0[2].cyc - log0[1].cyc), 32'd4);
      chk("t2_resume",    0, 32'(log0[3].cyc - log0[2].cyc), 32'd1);
    end

    // 3. Back-to-back bursts with no bubble.
    log0.delete();
    in_valid = 1'b1;
    wait_accept(0);
    load_set(255, 1, 0, 0, 0, 2);
    ok = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (in_ready[0]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t3_ready_seen", 0, 32'(ok), 32'd1);
    chk("t3_ready_idx", 0, 32'(out_idx[0]), 32'd6);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t3_next_idx",  0, 32'(out_idx[0]),  32'd0);
    chk("t3_next_data", 0, 32'(out_data[0]), 32'd255);
    repeat (12) @(posedge clk);
    #1;
    chk("t3_count", 0, 32'(log0.size()), 32'd14);
    if (log0.size() == 14) begin
      chk("t3_b0_data", 0, 32'(log0[7].d), 32'd255);
      chk("t3_no_bubble", 0, 32'(log0[7].cyc - log0[6].cyc), 32'd1);
      chk("t3_sum_data", 0, 32'(log0[13].d), 32'd2);
      chk("t3_sum_idx",  0, 32'(log0[13].i), 32'd6);
    end

    // 4. EMIT_SUM=0 instance: six beats, last on idx 5.
    log1.delete();
    load_set(1, 2, 3, 4, 5, 6);
    in_valid = 1'b1;
    wait_accept(1);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("t4_count", 1, 32'(log1.size()), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < log1.size()) begin
        chk("t4_data", 1, 32'(log1[k].d), 32'(k + 1));
        chk("t4_idx",  1, 32'(log1[k].i), 32'(k));
        chk("t4_last", 1, 32'(log1[k].l), 32'(k == 5));
      end
    end

    // 5. Reset mid-burst, then restart from idx 0.
    load_set(13, 30, 3, 33, 7, 40);
    in_valid = 1'b1;
    wait_accept(0);
    in_valid = 1'b0;
    wait_idx(0, 2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_out_valid", 0, 32'(out_valid[0]), 32'd0);
    chk("t5_busy",      0, 32'(busy[0]),      32'd0);
    chk("t5_out_idx",   0, 32'(out_idx[0]),   32'd0);
    chk("t5_in_ready",  0, 32'(in_ready[0]),  32'd1);
    @(posedge clk); #1;
    log0.delete();
    load_set(9, 8, 7, 6, 5, 4);
    in_valid = 1'b1;
    wait_accept(0);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("t5_count", 0, 32'(log0.size()), 32'd7);
    if (log0.size() == 7) begin
      chk("t5_first_idx",  0, 32'(log0[0].i), 32'd0);
      chk("t5_first_data", 0, 32'(log0[0].d), 32'd9);
      chk("t5_sum",        0, 32'(log0[6].d), 32'd39);
    end

    // 6. Random churn on every input, occasional reset.
    for (int t = 0; t < 800; t++) begin
      for (int k = 0; k < 6; k++) s[k] = BW'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 199) == 0);
      @(posedge clk); #1;
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("final_idle0", 0, 32'(busy[0]), 32'd0);
    chk("final_idle1", 1, 32'(busy[1]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
